irq_arbiter: RTL
================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, meaning the number of external interrupt sources (1..255).
REQ-002 SHALL have parameter ID_W, default 8, meaning the IRQ id width, matching irq_bus.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_src_i  input  NUM_IRQ  raw external interrupt lines, already synchronous to clk.
REQ-006 SHALL have port irq_en_we_i  input  1  write strobe for the enable mask.
REQ-007 SHALL have port irq_en_data_i  input  NUM_IRQ  new enable mask value.
REQ-008 SHALL have port irq_en_o  output  NUM_IRQ  current enable mask.
REQ-009 SHALL have port irq_flush_req_addr_o  output  ID_W  requested IRQ id; 0 means no request.
REQ-010 SHALL have port irq_acknowledge_i  input  1  core accepted the request (irq_ack level).
REQ-011 SHALL have port irq_done_i  input  1  one-cycle pulse when the core exits the handler.
REQ-012 SHALL have port irq_pending_o  output  NUM_IRQ  pending bits, for debug/CSR read.
REQ-013 SHALL have port irq_busy_o  output  1  high in the SERVICE state.

Function
REQ-014 Source k SHALL have IRQ id k+1. Id 0 is reserved for "none".
REQ-015 SHALL provide three states: IDLE, REQ and SERVICE.
REQ-016 IDLE -> REQ when (pending & enable) != 0. On that clock edge, the id of the lowest-index eligible source SHALL be registered into irq_flush_req_addr_o.
REQ-017 In REQ, irq_flush_req_addr_o SHALL stay stable until the cycle in which irq_acknowledge_i is sampled high, even if higher-priority sources assert.
REQ-018 REQ -> SERVICE on irq_acknowledge_i. On the same edge:
- the pending bit of the served source is cleared;
- irq_flush_req_addr_o goes to 0.
REQ-019 If the served source is disabled while in REQ, the block SHALL withdraw the request: REQ -> IDLE and the output goes to 0. The pending bit is kept.
REQ-020 SERVICE -> IDLE on irq_done_i. No new request SHALL be issued while in SERVICE; there is no nesting.
REQ-021 irq_done_i in IDLE or REQ SHALL be ignored.
REQ-022 Request latency SHALL be 1 cycle from an eligible pending bit to a nonzero irq_flush_req_addr_o.
REQ-023 Re-arbitration SHALL happen no earlier than the cycle after the return to IDLE.
REQ-024 If a set event and the ack-clear hit the same pending bit in the same cycle, the set SHALL win: the bit remains 1.
REQ-025 An enable-mask write SHALL take effect the next cycle. Pending bits SHALL latch regardless of the enable value.
REQ-026 irq_busy_o SHALL be registered and SHALL be 1 exactly while in SERVICE.

Reset
REQ-027 Reset SHALL force the following, asynchronously:
- state = IDLE;
- pending = 0;
- enable = 0;
- irq_flush_req_addr_o = 0;
- irq_busy_o = 0.
REQ-028 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction with no residual request after release.

Configuration
REQ-029 With IRQ_EDGE_DETECT_EN defined:
- the previous value of irq_src_i is registered (reset 0);
- a 0->1 transition sets the pending bit, which holds until ack-clear.
REQ-030 Without IRQ_EDGE_DETECT_EN:
- sources are level-sensitive and pending = irq_src_i each cycle;
- the ack-clear has no lasting effect; the source must deassert itself before irq_done_i or it is requested again.

Structure
REQ-031 State encodings, the id-0 "none" constant and ID_W default SHALL live in the shared define file alongside irq_bus, irq_ack and irq_nak.
REQ-032 The fixed-priority encoder SHALL be a sub-module named irq_prio_enc: NUM_IRQ-bit input, ID_W-bit id output, combinational.

Verification
REQ-033 Enable = 0xFF, pulse src[3] -> id 4 appears 1 cycle later; ack -> id 0, busy = 1; done -> busy = 0.
REQ-034 Enable = 0xFF, src[5] and src[1] asserted in the same cycle -> id 2 first; after done, id 6 (edge mode).
REQ-035 In REQ with id 3, assert src[0] -> id stays 3 until ack; id 1 is issued after done.
REQ-036 Enable = 0x00, pulse src[2] -> no request and pending[2] = 1; write enable = 0x04 -> id 3 two cycles after the write strobe.
REQ-037 Assert rst during SERVICE -> all outputs 0 immediately; after release with src idle, id stays 0.
REQ-038 Edge mode: src[4] rises in the same cycle the ack clears source 4 -> pending[4] remains 1 and id 5 is re-requested after done.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the IRQ arbiter: state encoding, id/bus width,
// the reserved "none" id and the acknowledge levels.
package irq_arbiter_pkg;

    localparam int ID_W_DEF    = 8;
    localparam int IRQ_ID_NONE = 0;

    typedef logic [ID_W_DEF-1:0] irq_bus_t;

    localparam logic IRQ_ACK = 1'b1;
    localparam logic IRQ_NAK = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// Request/acknowledge handshake between the IRQ arbiter (master) and the core (slave).
interface irq_arbiter_if
    import irq_arbiter_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
);
    logic [ID_W-1:0] irq_flush_req_addr_o;
    logic            irq_acknowledge_i;
    logic            irq_done_i;
    logic            irq_busy_o;

    modport master (
        output irq_flush_req_addr_o,
        output irq_busy_o,
        input  irq_acknowledge_i,
        input  irq_done_i
    );

    modport slave (
        input  irq_flush_req_addr_o,
        input  irq_busy_o,
        output irq_acknowledge_i,
        output irq_done_i
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit k yields id k+1, an empty vector yields the "none" id.
module irq_prio_enc
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_IRQ-1:0] vec,
    output logic [ID_W-1:0]    id
);

    // Scanning downwards lets the lowest index overwrite any higher one.
    always_comb begin
        id = ID_W'(IRQ_ID_NONE);
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (vec[k]) begin
                id = ID_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches sources, masks them and hands the core one request at a time.
// Build option IRQ_EDGE_DETECT_EN selects rising-edge latched sources instead of level sources.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no outstanding request, arbitrating each cycle
// ST_REQ     | id presented on the bus, held until ack or withdrawal
// ST_SERVICE | core is in the handler, waiting for done, no nesting
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               irq_en_we_i,
    input  logic [NUM_IRQ-1:0] irq_en_data_i,
    output logic [NUM_IRQ-1:0] irq_en_o,
    output logic [NUM_IRQ-1:0] irq_pending_o,
    irq_arbiter_if.master      bus
);

    irq_state_e         state_q, state_d;
    logic [ID_W-1:0]    addr_q, addr_d, win_id;
    logic               busy_q, busy_d;
    logic [NUM_IRQ-1:0] en_q, pend, elig, served_oh;
    logic               served_en, take_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else if (irq_en_we_i) begin
            en_q <= irq_en_data_i;
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_q, pend_q;

    // A new rising edge outranks the ack-clear of the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= irq_src_i;
            pend_q <= (pend_q & ~(served_oh & {NUM_IRQ{take_ack}})) | (irq_src_i & ~src_q);
        end
    end

    assign pend = pend_q;
`else
    assign pend = irq_src_i;
`endif

    assign elig = pend & en_q;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .vec (elig),
        .id  (win_id)
    );

    always_comb begin
        served_oh = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            served_oh[k] = (addr_q == ID_W'(k + 1));
        end
    end

    assign served_en = |(served_oh & en_q);
    assign take_ack  = (state_q == ST_REQ) && (bus.irq_acknowledge_i == IRQ_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= ID_W'(IRQ_ID_NONE);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (elig != '0) begin
                    state_d = ST_REQ;
                    addr_d  = win_id;
                end
            end
            ST_REQ: begin
                // Ack wins over a same-cycle mask change; otherwise a masked source is withdrawn.
                if (take_ack) begin
                    state_d = ST_SERVICE;
                    addr_d  = ID_W'(IRQ_ID_NONE);
                end else if (!served_en) begin
                    state_d = ST_IDLE;
                    addr_d  = ID_W'(IRQ_ID_NONE);
                end
            end
            ST_SERVICE: begin
                if (bus.irq_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = ID_W'(IRQ_ID_NONE);
            end
        endcase
        busy_d = (state_d == ST_SERVICE);
    end

    assign bus.irq_flush_req_addr_o = addr_q;
    assign bus.irq_busy_o           = busy_q;
    assign irq_en_o                 = en_q;
    assign irq_pending_o            = pend;

endmodule
